// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the bit-serial arithmetic blocks.
// The serial subtractor uses these today. A serial adder will reuse the same
// FSM encoding and the same default width.
//
// Contents:
//   ARITH_DEFAULT_WIDTH - default operand width for serial arithmetic blocks
//   arith_state_e       - control FSM states (IDLE / SHIFT / DONE)
// -----------------------------------------------------------------------------
package arith_pkg;

    localparam int unsigned ARITH_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } arith_state_e;

endpackage : arith_pkg

// File: rtl/full_sub.sv
// -----------------------------------------------------------------------------
// full_sub
// Combinational one-bit full subtractor: computes x - y - bi.
//
// Ports:
//   x   (in)  minuend bit
//   y   (in)  subtrahend bit
//   bi  (in)  borrow-in
//   d   (out) difference bit
//   bo  (out) borrow-out
// -----------------------------------------------------------------------------
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    // Borrow out occurs in two cases:
    //   - we subtract 1 from 0;
    //   - the operand bits are equal and a borrow is already pending.
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule : full_sub

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor that computes a - b, LSB first, one bit per clock.
// A start/done handshake frames each operation. The datapath is one full_sub
// cell plus a borrow flip-flop. diff/borrow are registered and hold their
// value until the next operation completes.
//
// Parameters:
//   WIDTH  operand/result width, 1..32
//
// Ports:
//   clk    (in)  clock, rising edge
//   rst    (in)  synchronous active-high reset
//   start  (in)  request; sampled only in IDLE
//   a      (in)  minuend, captured when start is accepted
//   b      (in)  subtrahend, captured with a
//   busy   (out) high while bits are being processed
//   done   (out) one-cycle pulse when diff/borrow have just been updated
//   diff   (out) (a - b) mod 2^WIDTH
//   borrow (out) 1 when unsigned a < b
// -----------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // The counter is sized to hold WIDTH itself, so it never wraps.
    localparam int unsigned        CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    arith_state_e     state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             bor_q,    bor_d;     // running borrow between bit steps
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;

    logic cell_d;
    logic cell_bo;

    // The single bit cell always looks at the current operand LSBs.
    full_sub u_cell (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .bi (bor_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; otherwise always_comb would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        bor_d    = bor_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    bor_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // The new difference bit enters at the MSB end. After WIDTH
                // steps, bit 0 of the result has reached position 0.
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = cell_d;
                a_sh_d           = a_sh_q >> 1;
                b_sh_d           = b_sh_q >> 1;
                bor_d            = cell_bo;
                cnt_d            = cnt_q + CNT_W'(1);

                if (cnt_q == LAST_BIT) begin
                    diff_d   = res_d;
                    borrow_d = cell_bo;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments here. Every register then samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are cleared along with the control
            // state, because diff/borrow must read 0 immediately after reset.
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            bor_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            bor_q    <= bor_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Outputs are decoded only from registers. No input reaches them
    // combinationally.
    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor.
// One instance uses WIDTH=8 and one uses WIDTH=1.
// Expected results are queued when a request is driven. They are compared when
// done pulses.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    // WIDTH = 8 instance
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    // WIDTH = 1 instance
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

    int checks   = 0;
    int passed   = 0;
    int failures = 0;
    int done_cnt = 0;
    int d0;

    logic [8:0] sb_q[$];
    logic [8:0] mon_exp;
    logic [1:0] w1_exp [4];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
        .borrow (borrow1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE, then wait (bounded) for its done pulse.
    // Returns one cycle after done, with the FSM back in IDLE.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv);
        int n;
        a     = av;
        b     = bv;
        start = 1'b1;
        sb_q.push_back({1'b0, av} - {1'b0, bv});
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("op_done_seen", done, 1);
        tick();
    endtask

    // Scoreboard: each done pulse pops the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            check("sb_nonempty_at_done", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                check("sb_diff", diff, mon_exp[7:0]);
                check("sb_borrow", borrow, mon_exp[8]);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        // Index is {a,b}; value is {borrow,diff}.
        w1_exp = '{2'b00, 2'b11, 2'b01, 2'b00};

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_busy",    busy,    0);
        check("rst_done",    done,    0);
        check("rst_diff",    diff,    0);
        check("rst_borrow",  borrow,  0);
        check("rst_busy1",   busy1,   0);
        check("rst_diff1",   diff1,   0);
        rst = 1'b0;
        tick();

        // ---------------- 5 - 3 with timing ----------------
        a     = 8'h05;
        b     = 8'h03;
        start = 1'b1;
        sb_q.push_back(9'h002);
        tick();                       // after T0
        start = 1'b0;
        a     = 8'hAA;                // operands may change after acceptance
        b     = 8'h55;
        for (int i = 0; i < 8; i++) begin
            check("t1_busy_high", busy, 1);
            check("t1_done_low",  done, 0);
            tick();
        end
        // after T0+8
        check("t1_busy_low", busy,   0);
        check("t1_done",     done,   1);
        check("t1_diff",     diff,   8'h02);
        check("t1_borrow",   borrow, 0);
        tick();
        check("t1_done_fall", done,     0);
        check("t1_done_cnt",  done_cnt, 1);

        // ---------------- directed corner operands ----------------
        do_op(8'h03, 8'h05);
        check("t2_diff_neg",   diff,   8'hFE);
        check("t2_borrow_neg", borrow, 1);
        do_op(8'h00, 8'h00);
        check("t2_diff_zero",   diff,   8'h00);
        check("t2_borrow_zero", borrow, 0);
        do_op(8'hFF, 8'hFF);
        check("t2_diff_ff",   diff,   8'h00);
        check("t2_borrow_ff", borrow, 0);

        // ---------------- start held / re-pulsed during SHIFT ----------------
        d0    = done_cnt;
        a     = 8'h20;
        b     = 8'h07;
        start = 1'b1;
        sb_q.push_back(9'h019);
        tick();                       // after T0
        a     = 8'h55;
        b     = 8'h11;
        for (int i = 1; i <= 10; i++) begin
            tick();                   // after T0+i
            if (i == 3) start = 1'b0;
            if (i == 4) start = 1'b1;
            if (i == 8) begin
                check("t3_done_at_8", done, 1);
                check("t3_busy_at_8", busy, 0);
                check("t3_first_result", diff, 8'h19);
            end
            if (i == 9) begin
                check("t3_idle_at_9", busy, 0);
                check("t3_done_at_9", done, 0);
                sb_q.push_back(9'h044);   // accepted on the coming edge
            end
            if (i == 10) begin
                check("t3_accept_at_10", busy, 1);
                start = 1'b0;
            end
        end
        begin
            int n;
            n = 0;
            while (done !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check("t3_second_done_seen", done, 1);
            tick();
        end
        check("t3_done_count", done_cnt, d0 + 2);
        check("t3_second_result", diff, 8'h44);

        // ---------------- reset mid-operation ----------------
        d0    = done_cnt;
        a     = 8'h40;
        b     = 8'h01;
        start = 1'b1;
        sb_q.push_back(9'h03F);
        tick();                       // after T0
        start = 1'b0;
        tick();
        tick();
        tick();                       // after T0+3
        rst = 1'b1;
        tick();                       // after T0+4
        check("t4_busy",   busy,   0);
        check("t4_done",   done,   0);
        check("t4_diff",   diff,   0);
        check("t4_borrow", borrow, 0);
        sb_q.delete();
        rst = 1'b0;
        repeat (12) tick();
        check("t4_no_done_after_abort", done_cnt, d0);

        // Reset and start high on the same edge: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        tick();
        check("t4_rst_wins", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("t4_no_late_accept", busy, 0);

        do_op(8'h10, 8'h01);
        check("t4_fresh_diff",   diff,   8'h0F);
        check("t4_fresh_borrow", borrow, 0);

        // ---------------- WIDTH = 1 truth table ----------------
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab     = 2'(i);
            a1     = ab[1];
            b1     = ab[0];
            start1 = 1'b1;
            tick();                   // accepted
            start1 = 1'b0;
            tick();                   // 2 cycles after start: result registered
            check("w1_done",   done1,   1);
            check("w1_diff",   diff1,   w1_exp[i][0]);
            check("w1_borrow", borrow1, w1_exp[i][1]);
            tick();
        end

        // ---------------- randomised sweep ----------------
        for (int i = 0; i < 500; i++) begin
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_serial_subtractor
